// File: rtl/integration_pkg.sv
// Shared types and constants for the AHB integration slice: arbitration policy
// enum, default master count and an index-width helper.
package integration_pkg;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_e;

  localparam int master_number = 4;

  // Index width for n masters; a single master still needs one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational next-owner search: lowest-index requester in fixed mode, or the
// first requester found cyclically from i_start in round-robin mode.
module ahb_arb_pick
  import integration_pkg::*;
#(
  parameter int N  = master_number,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  input  arb_mode_e     i_mode,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW:0] w_pos;

  // Both searches run from the far end down so the last hit is the winner.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    if (i_mode == ARB_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_idx   = IW'(i);
          o_valid = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        w_pos = {1'b0, i_start} + (IW + 1)'(k);
        if (w_pos >= (IW + 1)'(N)) begin
          w_pos = w_pos - (IW + 1)'(N);
        end
        if (i_req[w_pos[IW-1:0]]) begin
          o_idx   = w_pos[IW-1:0];
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: registered grant index with lock hold, fixed-priority or
// round-robin selection with optional tenure limit, and hmaster lagging hgrant.
module ahb_arbiter
  import integration_pkg::*;
#(
  parameter int        MASTER_NUMBER = master_number,
  parameter arb_mode_e ARB_MODE      = ARB_FIXED,
  parameter int        MAX_TENURE    = 0
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [MASTER_NUMBER-1:0] hbusreq,
  input  logic [MASTER_NUMBER-1:0] hlock,
  input  logic                     hready,
  output logic [MASTER_NUMBER-1:0] hgrant,
  output logic [3:0]               hmaster,
  output logic                     hmastlock
);

  localparam int IW             = idxWidth(MASTER_NUMBER);
  localparam int DEFAULT_MASTER = MASTER_NUMBER - 1;
  localparam int TW             = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;

  logic [IW-1:0] r_gntIdx;
  logic [3:0]    r_hmaster;
  logic [TW-1:0] r_tenure;

  logic [IW-1:0] w_start;
  logic [IW-1:0] w_pickIdx;
  logic          w_pickValid;
  logic          w_ownerReq;
  logic          w_locked;
  logic          w_expired;
  logic          w_regrant;
  logic [IW-1:0] w_nextIdx;
  logic [TW-1:0] w_nextTenure;

  // The grant index doubles as the rotation pointer: search begins just past it.
  assign w_start = (r_gntIdx == IW'(DEFAULT_MASTER)) ? '0 : r_gntIdx + 1'b1;

  ahb_arb_pick #(
    .N  (MASTER_NUMBER),
    .IW (IW)
  ) u_pick (
    .i_req   (hbusreq),
    .i_start (w_start),
    .i_mode  (ARB_MODE),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

  assign w_ownerReq = hbusreq[r_gntIdx];
  assign w_locked   = hlock[r_gntIdx] && w_ownerReq;
  assign w_expired  = (MAX_TENURE != 0) && (r_tenure == TW'(MAX_TENURE));
  assign w_regrant  = (ARB_MODE == ARB_ROUND_ROBIN) && !w_locked && w_expired;

  always_comb begin
    w_nextIdx    = IW'(DEFAULT_MASTER);
    w_nextTenure = '0;
    if (w_locked) begin
      w_nextIdx = r_gntIdx;
    end else if ((ARB_MODE == ARB_ROUND_ROBIN) && w_ownerReq && !w_expired) begin
      w_nextIdx = r_gntIdx;
    end else if (w_pickValid) begin
      w_nextIdx = w_pickIdx;
    end
    // An expired owner that wins again as sole requester starts a fresh tenure.
    if ((w_nextIdx == r_gntIdx) && !w_regrant) begin
      w_nextTenure = (r_tenure == TW'(MAX_TENURE)) ? r_tenure : r_tenure + 1'b1;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_gntIdx  <= IW'(DEFAULT_MASTER);
      r_hmaster <= 4'(DEFAULT_MASTER);
      r_tenure  <= '0;
    end else if (hready) begin
      r_gntIdx  <= w_nextIdx;
      r_hmaster <= 4'(r_gntIdx);
      r_tenure  <= w_nextTenure;
    end
  end

  assign hgrant    = MASTER_NUMBER'(1) << r_gntIdx;
  assign hmaster   = r_hmaster;
  assign hmastlock = hlock[r_gntIdx];

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench: a fixed-priority and a round-robin (tenure 3) arbiter share
// the same stimulus; a negedge monitor checks one-hot, hmaster lag and hmastlock.
module tb_ahb_arbiter;
  import integration_pkg::*;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic       hready;
  logic [3:0] gntF, hmF;
  logic       mlF;
  logic [3:0] gntR, hmR;
  logic       mlR;

  int total = 0;
  int bad   = 0;
  logic [3:0] expHmF = 4'd3;
  logic [3:0] expHmR = 4'd3;
  logic [3:0] rrSeq [21];

  ahb_arbiter #(
    .MASTER_NUMBER (4),
    .ARB_MODE      (ARB_FIXED),
    .MAX_TENURE    (0)
  ) u_fix (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .hready    (hready),
    .hgrant    (gntF),
    .hmaster   (hmF),
    .hmastlock (mlF)
  );

  ahb_arbiter #(
    .MASTER_NUMBER (4),
    .ARB_MODE      (ARB_ROUND_ROBIN),
    .MAX_TENURE    (3)
  ) u_rr (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .hready    (hready),
    .hgrant    (gntR),
    .hmaster   (hmR),
    .hmastlock (mlR)
  );

  always #5 hclk = ~hclk;

  function automatic logic [3:0] oneHotIdx(input logic [3:0] g);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = 4'(i);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock, input logic rdy);
    hbusreq = req;
    hlock   = lock;
    hready  = rdy;
  endtask

  task automatic cycle();
    @(posedge hclk);
    #1;
  endtask

  // Invariants on both arbiters, sampled on the falling edge.
  always @(negedge hclk) begin
    checkOutput("fix_onehot", {3'd0, $onehot(gntF)}, 4'd1);
    checkOutput("rr_onehot", {3'd0, $onehot(gntR)}, 4'd1);
    checkOutput("fix_mastlock", {3'd0, mlF}, {3'd0, hlock[oneHotIdx(gntF)]});
    checkOutput("rr_mastlock", {3'd0, mlR}, {3'd0, hlock[oneHotIdx(gntR)]});
    if (hreset) begin
      expHmF = 4'd3;
      expHmR = 4'd3;
    end
    checkOutput("fix_hmaster_lag", hmF, expHmF);
    checkOutput("rr_hmaster_lag", hmR, expHmR);
    if (!hreset && hready) begin
      expHmF = oneHotIdx(gntF);
      expHmR = oneHotIdx(gntR);
    end
  end

  always @(posedge hreset) begin
    expHmF = 4'd3;
    expHmR = 4'd3;
  end

  initial begin
    rrSeq = '{4'b1000, 4'b1000, 4'b1000,
              4'b0001, 4'b0001, 4'b0001, 4'b0001,
              4'b0010, 4'b0010, 4'b0010, 4'b0010,
              4'b0100, 4'b0100, 4'b0100, 4'b0100,
              4'b1000, 4'b1000, 4'b1000, 4'b1000,
              4'b0001, 4'b0001};

    // Reset state
    hreset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #1;
    checkOutput("reset_hgrant", gntF, 4'b1000);
    checkOutput("reset_hmaster", hmF, 4'd3);
    checkOutput("reset_rr_hgrant", gntR, 4'b1000);
    cycle();
    cycle();
    hreset = 1'b0;

    // Idle bus parks on the default master
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("idle_hgrant", gntF, 4'b1000);
      checkOutput("idle_hmaster", hmF, 4'd3);
    end

    // Fixed priority picks lowest requester, then preempts for master 0
    applyStimulus(4'b0110, 4'b0000, 1'b1);
    cycle();
    checkOutput("fix_first_grant", gntF, 4'b0010);
    checkOutput("fix_hmaster_old", hmF, 4'd3);
    cycle();
    checkOutput("fix_hmaster_1", hmF, 4'd1);
    applyStimulus(4'b0111, 4'b0000, 1'b1);
    cycle();
    checkOutput("fix_preempt", gntF, 4'b0001);
    checkOutput("fix_preempt_hm", hmF, 4'd1);

    // Locked master 2 holds the bus; hlock[0] of a non-owner is ignored
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    cycle();
    checkOutput("lock_setup", gntF, 4'b0100);
    applyStimulus(4'b0101, 4'b0101, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("lock_hold", gntF, 4'b0100);
      checkOutput("lock_mastlock", {3'd0, mlF}, 4'd1);
    end
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    cycle();
    checkOutput("lock_release", gntF, 4'b0001);
    checkOutput("lock_release_ml", {3'd0, mlF}, 4'd0);
    checkOutput("lock_release_hm", hmF, 4'd2);

    // Wait states freeze every output while requests move
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkOutput("wait_hgrant", gntF, 4'b0001);
      checkOutput("wait_hmaster", hmF, 4'd2);
    end
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    cycle();
    checkOutput("wait_decide", gntF, 4'b0010);
    checkOutput("wait_decide_hm", hmF, 4'd0);

    // Asynchronous reset in the middle of a locked transfer
    applyStimulus(4'b0010, 4'b0010, 1'b1);
    cycle();
    checkOutput("prelock_hgrant", gntF, 4'b0010);
    checkOutput("prelock_ml", {3'd0, mlF}, 4'd1);
    #2;
    hreset = 1'b1;
    #1;
    checkOutput("async_hgrant", gntF, 4'b1000);
    checkOutput("async_hmaster", hmF, 4'd3);
    cycle();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    hreset = 1'b0;
    cycle();
    checkOutput("post_reset", gntF, 4'b1000);

    // Round-robin rotation with tenure 3, all masters requesting
    hreset = 1'b1;
    cycle();
    hreset = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    for (int k = 0; k < 21; k++) begin
      cycle();
      checkOutput($sformatf("rr_seq_%0d", k + 1), gntR, rrSeq[k]);
      checkOutput("fix_all_req", gntF, 4'b0001);
    end

    // Sole requester regrant restarts its tenure
    hreset = 1'b1;
    cycle();
    hreset = 1'b0;
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      checkOutput("rr_sole", gntR, 4'b0100);
    end
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("rr_fresh_tenure", gntR, 4'b0100);
    end
    cycle();
    checkOutput("rr_rotate_wrap", gntR, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
